// File: rtl/fast_square_pkg.sv
// rtl/fast_square_pkg.sv - shared types and constants for the fast square sweep controller
//
// Purpose: state enumeration, counter widths and FIFO word packing order
// used by fast_square_sweep_ctrl.
// Contents:
//   STROBE_CNT_W  - width of the per-state baseband strobe counter
//   STEP_IDX_W    - width of the frequency step index
//   state_e       - sweep controller states
//   pack_wr_data  - builds the FIFO word from the baseband sign-bit words
package fast_square_pkg;

  localparam int STROBE_CNT_W = 16;
  localparam int STEP_IDX_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RECORD  = 3'd3,
    ST_STEP    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Q occupies the upper half of the FIFO word, I the lower half.
  function automatic logic [31:0] pack_wr_data(input logic [15:0] q_w,
                                               input logic [15:0] i_w);
    return {q_w, i_w};
  endfunction

endpackage

// File: rtl/fast_square_sweep_ctrl.sv
// rtl/fast_square_sweep_ctrl.sv - frequency sweep sequencer for the fast square baseband capture
//
// Purpose: for each of NUM_STEPS synthesizer steps, restart the baseband
// block, discard SETTLE_WORDS strobes, then forward RECORD_WORDS strobes
// to a downstream FIFO, counting words dropped to backpressure.
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   start, abort         - begin a sweep from idle / terminate a sweep
//   bb_strobe            - baseband word-valid pulse
//   i_word, q_word       - baseband sign-bit words
//   fifo_full            - downstream FIFO cannot accept a word
//   bb_reset             - one-cycle restart pulse to the baseband block
//   freq_step            - one-cycle synthesizer step pulse
//   record               - high while recording
//   wr_en, wr_data       - FIFO write strobe and word {q_word, i_word}
//   step_idx             - current frequency step
//   busy, done           - sweep active / one-cycle completion pulse
//   overflow, drop_cnt   - sticky drop flag and saturating drop count
module fast_square_sweep_ctrl
  import fast_square_pkg::*;
#(
  parameter int NUM_STEPS    = 16,
  parameter int SETTLE_WORDS = 202,
  parameter int RECORD_WORDS = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    bb_strobe,
  input  logic [15:0]             i_word,
  input  logic [15:0]             q_word,
  input  logic                    fifo_full,
  output logic                    bb_reset,
  output logic                    freq_step,
  output logic                    record,
  output logic                    wr_en,
  output logic [31:0]             wr_data,
  output logic [STEP_IDX_W-1:0]   step_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [STROBE_CNT_W-1:0] drop_cnt
);

  // Terminal counts are compared against the count before the strobe is
  // added, so the counter never exceeds WORDS-1 and cannot wrap.
  localparam logic [STROBE_CNT_W-1:0] SETTLE_LAST = STROBE_CNT_W'(SETTLE_WORDS - 1);
  localparam logic [STROBE_CNT_W-1:0] RECORD_LAST = STROBE_CNT_W'(RECORD_WORDS - 1);
  localparam logic [STEP_IDX_W-1:0]   LAST_STEP   = STEP_IDX_W'(NUM_STEPS - 1);

  state_e                  state_q, state_d;
  logic [STROBE_CNT_W-1:0] strobe_cnt_q, strobe_cnt_d;
  logic [STEP_IDX_W-1:0]   step_idx_q, step_idx_d;
  logic                    overflow_q, overflow_d;
  logic [STROBE_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic start_ok;
  logic strobe_ok;

  assign start_ok  = start & ~abort;
  // abort outranks a coincident strobe: that strobe is neither written nor counted
  assign strobe_ok = bb_strobe & ~abort;

  // State register and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      strobe_cnt_q <= '0;
      step_idx_q   <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      strobe_cnt_q <= strobe_cnt_d;
      step_idx_q   <= step_idx_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_ok) state_d = ST_RESTART;
      ST_RESTART: state_d = ST_SETTLE;
      ST_SETTLE:  if (bb_strobe && strobe_cnt_q == SETTLE_LAST) state_d = ST_RECORD;
      ST_RECORD:  if (bb_strobe && strobe_cnt_q == RECORD_LAST)
                    state_d = (step_idx_q < LAST_STEP) ? ST_STEP : ST_DONE;
      ST_STEP:    state_d = ST_RESTART;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  // Counter next-state logic
  always_comb begin
    strobe_cnt_d = strobe_cnt_q;
    step_idx_d   = step_idx_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          step_idx_d = '0;
          overflow_d = 1'b0;
          drop_cnt_d = '0;
        end
      end
      ST_RESTART: strobe_cnt_d = '0;
      ST_SETTLE: begin
        if (strobe_ok)
          strobe_cnt_d = (strobe_cnt_q == SETTLE_LAST) ? '0 : strobe_cnt_q + 1'b1;
      end
      ST_RECORD: begin
        if (strobe_ok) begin
          strobe_cnt_d = (strobe_cnt_q == RECORD_LAST) ? '0 : strobe_cnt_q + 1'b1;
          if (fifo_full) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
          end
        end
      end
      ST_STEP: if (!abort) step_idx_d = step_idx_q + 1'b1;
      default: ;
    endcase
  end

  // Outputs decoded from state; held quiet while reset is asserted
  always_comb begin
    bb_reset  = 1'b0;
    freq_step = 1'b0;
    done      = 1'b0;
    record    = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    if (!reset) begin
      busy = (state_q != ST_IDLE);
      unique case (state_q)
        ST_RESTART: bb_reset  = ~abort;
        ST_STEP:    freq_step = ~abort;
        ST_DONE:    done      = ~abort;
        ST_RECORD: begin
          record = 1'b1;
          wr_en  = bb_strobe & ~fifo_full & ~abort;
        end
        default: ;
      endcase
    end
  end

  assign wr_data  = pack_wr_data(q_word, i_word);
  assign step_idx = step_idx_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// tb/tb_fast_square_sweep_ctrl.sv - self-checking bench for fast_square_sweep_ctrl
module tb_fast_square_sweep_ctrl;

  localparam int NS = 2;
  localparam int SW = 3;
  localparam int RW = 4;

  localparam int P_IDLE = 0, P_RST = 1, P_SET = 2, P_REC = 3, P_STP = 4, P_DN = 5;

  logic        clock = 1'b0;
  logic        reset, start, abort, bb_strobe, fifo_full;
  logic [15:0] i_word, q_word;
  logic        bb_reset, freq_step, record, wr_en, busy, done, overflow;
  logic [31:0] wr_data;
  logic [7:0]  step_idx;
  logic [15:0] drop_cnt;

  fast_square_sweep_ctrl #(.NUM_STEPS(NS), .SETTLE_WORDS(SW), .RECORD_WORDS(RW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .bb_strobe(bb_strobe), .i_word(i_word), .q_word(q_word), .fifo_full(fifo_full),
    .bb_reset(bb_reset), .freq_step(freq_step), .record(record),
    .wr_en(wr_en), .wr_data(wr_data), .step_idx(step_idx), .busy(busy),
    .done(done), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: phase of the sweep plus words seen in the current phase
  int m_ph, m_cnt, m_step, m_drop;
  bit m_ovf;

  int wr_cnt, wr0_cnt, bbr_cnt, fs_cnt, dn_cnt;

  typedef struct {
    bit r, s, a, b, f;
    logic [15:0] iw, qw;
    bit busy, rec, bbr, fs, dn, we;
    logic [7:0] sidx;
    bit ovf;
    logic [15:0] drop;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit r, s, a, b, f, input logic [15:0] iw, qw);
    reset = r; start = s; abort = a; bb_strobe = b; fifo_full = f;
    i_word = iw; q_word = qw;
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_cnt = 0; m_step = 0; m_drop = 0; m_ovf = 0;
  endtask

  task automatic model_update();
    if (reset) begin
      model_reset();
    end else if (m_ph == P_IDLE) begin
      if (start && !abort) begin
        m_ph = P_RST; m_step = 0; m_ovf = 0; m_drop = 0;
      end
    end else if (abort) begin
      m_ph = P_IDLE;
    end else begin
      case (m_ph)
        P_RST: begin m_ph = P_SET; m_cnt = 0; end
        P_SET: if (bb_strobe) begin
          m_cnt++;
          if (m_cnt == SW) begin m_ph = P_REC; m_cnt = 0; end
        end
        P_REC: if (bb_strobe) begin
          m_cnt++;
          if (fifo_full) begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
          end
          if (m_cnt == RW) m_ph = (m_step < NS - 1) ? P_STP : P_DN;
        end
        P_STP: begin m_step++; m_ph = P_RST; end
        P_DN:  m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  task automatic model_check();
    bit live;
    live = !reset;
    chk("busy",      busy,      live && m_ph != P_IDLE);
    chk("record",    record,    live && m_ph == P_REC);
    chk("bb_reset",  bb_reset,  live && m_ph == P_RST && !abort);
    chk("freq_step", freq_step, live && m_ph == P_STP && !abort);
    chk("done",      done,      live && m_ph == P_DN && !abort);
    chk("wr_en",     wr_en,     live && m_ph == P_REC && bb_strobe && !fifo_full && !abort);
    chk("wr_data",   wr_data,   {q_word, i_word});
    chk("step_idx",  step_idx,  m_step);
    chk("overflow",  overflow,  m_ovf);
    chk("drop_cnt",  drop_cnt,  m_drop);
  endtask

  task automatic cycle(input bit do_check);
    @(negedge clock);
    if (do_check) model_check();
    wr_cnt  += int'(wr_en === 1'b1);
    wr0_cnt += int'(wr_en === 1'b1 && step_idx == 8'd0);
    bbr_cnt += int'(bb_reset === 1'b1);
    fs_cnt  += int'(freq_step === 1'b1);
    dn_cnt  += int'(done === 1'b1);
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic clear_tallies();
    wr_cnt = 0; wr0_cnt = 0; bbr_cnt = 0; fs_cnt = 0; dn_cnt = 0;
  endtask

  // Full sweep, strobe every 16 cycles; optional drop on the 2nd recorded word of step 0
  task automatic sweep(input bit bp, input bit poke_start);
    bit b, f, s;
    clear_tallies();
    set_in(0, 1, 0, 0, 0, 16'h0, 16'h0);
    cycle(1);
    for (int k = 0; k < 600 && dn_cnt == 0; k++) begin
      b = (k % 16 == 15);
      f = bp && b && m_ph == P_REC && m_cnt == 1 && m_step == 0;
      s = poke_start && (k == 5 || k == 70);
      set_in(0, s, 0, b, f, 16'($urandom), 16'($urandom));
      cycle(1);
    end
    set_in(0, 0, 0, 0, 0, 16'h0, 16'h0);
    cycle(1);
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0,0, 16'h0,16'h0,       0,0,0,0,0,0, 8'd0,0,16'd0};
    tbl[1]  = '{0,0,0,0,0, 16'h0,16'h0,       0,0,0,0,0,0, 8'd0,0,16'd0};
    tbl[2]  = '{0,1,1,0,0, 16'h0,16'h0,       0,0,0,0,0,0, 8'd0,0,16'd0};
    tbl[3]  = '{0,1,0,0,0, 16'h0,16'h0,       0,0,0,0,0,0, 8'd0,0,16'd0};
    tbl[4]  = '{0,1,0,0,0, 16'h0,16'h0,       1,0,1,0,0,0, 8'd0,0,16'd0};
    tbl[5]  = '{0,0,0,1,0, 16'h0,16'h0,       1,0,0,0,0,0, 8'd0,0,16'd0};
    tbl[6]  = '{0,0,0,1,0, 16'h0,16'h0,       1,0,0,0,0,0, 8'd0,0,16'd0};
    tbl[7]  = '{0,0,0,1,0, 16'h0,16'h0,       1,0,0,0,0,0, 8'd0,0,16'd0};
    tbl[8]  = '{0,0,0,1,0, 16'h00A5,16'h5A00, 1,1,0,0,0,1, 8'd0,0,16'd0};
    tbl[9]  = '{0,0,0,1,1, 16'h0,16'h0,       1,1,0,0,0,0, 8'd0,0,16'd0};
    tbl[10] = '{0,0,1,1,0, 16'h0,16'h0,       1,1,0,0,0,0, 8'd0,1,16'd1};
    tbl[11] = '{0,0,0,0,0, 16'h0,16'h0,       0,0,0,0,0,0, 8'd0,1,16'd1};
    tbl[12] = '{0,1,0,0,0, 16'h0,16'h0,       0,0,0,0,0,0, 8'd0,1,16'd1};
    tbl[13] = '{0,0,1,0,0, 16'h0,16'h0,       1,0,0,0,0,0, 8'd0,0,16'd0};
    tbl[14] = '{0,0,0,0,0, 16'h0,16'h0,       0,0,0,0,0,0, 8'd0,0,16'd0};

    model_reset();
    clear_tallies();
    set_in(1, 0, 0, 0, 0, 16'h0, 16'h0);
    cycle(0);
    cycle(0);

    // Table-driven vectors: each row is the inputs and outputs of one cycle
    for (int n = 0; n < 15; n++) begin
      set_in(tbl[n].r, tbl[n].s, tbl[n].a, tbl[n].b, tbl[n].f, tbl[n].iw, tbl[n].qw);
      @(negedge clock);
      chk($sformatf("t%0d_busy", n),     busy,      tbl[n].busy);
      chk($sformatf("t%0d_record", n),   record,    tbl[n].rec);
      chk($sformatf("t%0d_bb_reset", n), bb_reset,  tbl[n].bbr);
      chk($sformatf("t%0d_freq_step", n),freq_step, tbl[n].fs);
      chk($sformatf("t%0d_done", n),     done,      tbl[n].dn);
      chk($sformatf("t%0d_wr_en", n),    wr_en,     tbl[n].we);
      chk($sformatf("t%0d_wr_data", n),  wr_data,   {tbl[n].qw, tbl[n].iw});
      chk($sformatf("t%0d_step_idx", n), step_idx,  tbl[n].sidx);
      chk($sformatf("t%0d_overflow", n), overflow,  tbl[n].ovf);
      chk($sformatf("t%0d_drop_cnt", n), drop_cnt,  tbl[n].drop);
      @(posedge clock);
      model_update();
      #1;
    end

    // Clean full sweep
    sweep(0, 0);
    chk("sweep_bb_reset_count",  bbr_cnt, 2);
    chk("sweep_freq_step_count", fs_cnt,  1);
    chk("sweep_write_count",     wr_cnt,  8);
    chk("sweep_done_count",      dn_cnt,  1);
    chk("sweep_step_idx_final",  step_idx, 1);
    chk("sweep_overflow",        overflow, 0);

    // Backpressure on 2nd recorded word of step 0, with starts while busy
    sweep(1, 1);
    chk("bp_write_count",   wr_cnt,  7);
    chk("bp_step0_writes",  wr0_cnt, 3);
    chk("bp_done_count",    dn_cnt,  1);
    chk("bp_overflow",      overflow, 1);
    chk("bp_drop_cnt",      drop_cnt, 1);

    // Reset in the middle of SETTLE
    clear_tallies();
    set_in(0, 1, 0, 0, 0, 16'h0, 16'h0);
    cycle(1);
    for (int k = 0; k < 50 && !(m_ph == P_SET && m_cnt >= 1); k++) begin
      set_in(0, 0, 0, (k % 4 == 3), 0, 16'h0, 16'h0);
      cycle(1);
    end
    set_in(0, 0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("pre_reset_busy", busy, 1);
    @(posedge clock);
    model_update();
    #1;
    set_in(1, 0, 0, 1, 0, 16'h0, 16'h0);
    cycle(1);
    set_in(0, 0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("post_reset_busy",   busy, 0);
    chk("post_reset_outs",   {bb_reset, freq_step, record, wr_en, done}, 0);
    chk("reset_no_freq_step", fs_cnt, 0);
    @(posedge clock);
    model_update();
    #1;

    // Randomized stimulus against the reference model
    for (int k = 0; k < 4000; k++) begin
      set_in($urandom_range(0, 599) == 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 149) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 4) == 0,
             16'($urandom), 16'($urandom));
      cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
